// File: rtl/debug_view_ctrl.sv
// Front-panel controller: debounces three pushbuttons into a display-mode select,
// a register-file debug index and a single-cycle CPU step enable.

module debug_view_btn #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             db;
  logic             db_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      db      <= 1'b0;
      db_prev <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;

      // Any return to the accepted level restarts the stability window.
      if (sync_2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= sync_2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      db_prev <= db;
      press   <= db & ~db_prev;
    end
  end

endmodule

module debug_view_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_MODES       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_reg,
  input  logic       btn_step,
  output logic [2:0] sel,
  output logic [4:0] reg_idx,
  output logic       step_pulse
);

  localparam logic [2:0] SEL_LAST = 3'(NUM_MODES - 1);

  logic press_mode;
  logic press_reg;
  logic press_step;

  debug_view_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_mode (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_mode),
    .press (press_mode)
  );

  debug_view_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_reg (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_reg),
    .press (press_reg)
  );

  debug_view_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_step (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_step),
    .press (press_step)
  );

  // Presses are independent; simultaneous events all land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel        <= 3'd0;
      reg_idx    <= 5'd0;
      step_pulse <= 1'b0;
    end else begin
      if (press_mode) begin
        sel <= (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
      end
      if (press_reg) begin
        reg_idx <= reg_idx + 5'd1;
      end
      step_pulse <= press_step;
    end
  end

endmodule

// File: tb/tb_debug_view_ctrl.sv
// Self-checking bench for debug_view_ctrl: directed front-panel scenarios plus
// random button activity, all compared against a window/delay-line reference model.

module tb_debug_view_ctrl;

  localparam int DB = 4;
  localparam int NM = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] btn = 3'b000;
  logic [2:0] sel;
  logic [4:0] reg_idx;
  logic       step_pulse;

  int n_chk  = 0;
  int n_fail = 0;
  int n_step = 0;

  debug_view_ctrl #(.DEBOUNCE_CYCLES(DB), .NUM_MODES(NM)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_mode   (btn[0]),
    .btn_reg    (btn[1]),
    .btn_step   (btn[2]),
    .sel        (sel),
    .reg_idx    (reg_idx),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a button level is accepted once the last DB samples all
  // disagree with it; a resulting press shows on the outputs 4 edges later
  // (2 synchronizer edges of the 7-edge latency are folded into the sample point).
  bit [DB-1:0] hist [3];
  bit          mdb  [3];
  bit [3:0]    dly  [3];
  int          sel_m, idx_m, step_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        hist[b] = '0;
        mdb[b]  = 1'b0;
        dly[b]  = '0;
      end
      sel_m  = 0;
      idx_m  = 0;
      step_m = 0;
    end else begin
      step_m = 0;
      if (dly[0][3]) sel_m = (sel_m + 1) % NM;
      if (dly[1][3]) idx_m = (idx_m + 1) % 32;
      if (dly[2][3]) step_m = 1;
      for (int b = 0; b < 3; b++) begin
        bit rise;
        rise    = 1'b0;
        hist[b] = {hist[b][DB-2:0], btn[b]};
        if (hist[b] == {DB{~mdb[b]}}) begin
          mdb[b] = ~mdb[b];
          rise   = mdb[b];
        end
        dly[b] = {dly[b][2:0], rise};
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_sel", sel, sel_m);
      chk("model_reg_idx", reg_idx, idx_m);
      chk("model_step", step_pulse, step_m);
    end
    if (step_pulse) n_step++;
  end

  initial begin
    int saved_sel, saved_idx;
    int run [3];

    // Reset asserted with no clock edge yet
    #1 rst = 1'b1;
    #1;
    chk("rst_sel", sel, 0);
    chk("rst_reg_idx", reg_idx, 0);
    chk("rst_step", step_pulse, 0);
    tick(3);
    rst = 1'b0;
    tick(3);

    // Reset in the middle of a mode press: press must be re-debounced
    btn[0] = 1'b1;
    tick(4);
    #1 rst = 1'b1;
    #1 chk("midrst_sel_async", sel, 0);
    #1 rst = 1'b0;
    tick(4);
    chk("midrst_sel_no_event", sel, 0);
    tick(4);
    chk("midrst_sel_redebounced", sel, 1);
    btn[0] = 1'b0;
    tick(12);

    // Mode wrap with exact latency check
    for (int k = 0; k < NM; k++) begin
      saved_sel = sel;
      btn[0] = 1'b1;
      tick(7);
      chk("mode_before_latency", sel, saved_sel);
      tick(1);
      chk("mode_at_latency", sel, (saved_sel + 1) % NM);
      tick(2);
      btn[0] = 1'b0;
      tick(10);
    end
    chk("mode_wrapped_back", sel, 1);

    // Register index wrap across 33 presses
    saved_sel = sel;
    saved_idx = reg_idx;
    for (int k = 0; k < 33; k++) begin
      btn[1] = 1'b1;
      tick(10);
      btn[1] = 1'b0;
      tick(10);
    end
    chk("reg_wrap_idx", reg_idx, (saved_idx + 33) % 32);
    chk("reg_wrap_sel_kept", sel, saved_sel);

    // Bounce rejection on step
    n_step = 0;
    btn[2] = 1'b1; tick(3);
    btn[2] = 1'b0; tick(1);
    btn[2] = 1'b1; tick(2);
    btn[2] = 1'b0; tick(1);
    tick(6);
    chk("bounce_no_pulse", n_step, 0);
    btn[2] = 1'b1; tick(10);
    btn[2] = 1'b0; tick(12);
    chk("bounce_one_pulse", n_step, 1);

    // Long hold gives exactly one pulse
    n_step = 0;
    btn[2] = 1'b1; tick(100);
    btn[2] = 1'b0; tick(12);
    chk("hold_one_pulse", n_step, 1);

    // Simultaneous mode + reg press land on the same edge
    saved_sel = sel;
    saved_idx = reg_idx;
    btn[1:0] = 2'b11;
    tick(7);
    chk("simul_sel_before", sel, saved_sel);
    chk("simul_idx_before", reg_idx, saved_idx);
    tick(1);
    chk("simul_sel_after", sel, (saved_sel + 1) % NM);
    chk("simul_idx_after", reg_idx, (saved_idx + 1) % 32);
    tick(4);
    btn[1:0] = 2'b00;
    tick(12);

    // Random activity with short bounces and long holds, plus an async reset
    for (int b = 0; b < 3; b++) run[b] = $urandom_range(1, 9);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (run[b] == 0) begin
          btn[b] = ~btn[b];
          run[b] = $urandom_range(1, 9);
        end
        run[b]--;
      end
      if (c == 300) begin
        #2 rst = 1'b1;
        #1;
        chk("rand_rst_sel", sel, 0);
        chk("rand_rst_reg_idx", reg_idx, 0);
        chk("rand_rst_step", step_pulse, 0);
        #1 rst = 1'b0;
      end
      tick(1);
    end
    btn = 3'b000;
    tick(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_view_ctrl.md
# debug_view_ctrl

Front-panel controller for the single-cycle CPU board. It debounces three raw pushbuttons. From two of them it produces the `sel` code and register index that drive the hex display multiplexer and the register-file debug read port. From the third it produces a one-cycle `step_pulse`, which is the CPU clock-enable for single-step execution. All outputs are registered and glitch-free, so the display stage downstream can consume them directly.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a button level change is accepted (10 ms at 50 MHz). Legal range is 2..2^24-1.
- `NUM_MODES`, default 6: number of display modes; `sel` counts 0..NUM_MODES-1. Legal range is 1..8.

Ports:
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `btn_mode`  in  1: raw display-mode button, active-high, asynchronous to `clk`.
- `btn_reg`  in  1: raw register-index button, active-high, asynchronous.
- `btn_step`  in  1: raw single-step button, active-high, asynchronous.
- `sel`  out  3: display mode to the hex display mux:
  - 0 = PC low, 1 = PC high
  - 2 = register low, 3 = register high
  - 4 = instruction low, 5 = instruction high
- `reg_idx`  out  5: register-file debug read address, 0..31.
- `step_pulse`  out  1: one-cycle CPU clock-enable per accepted step press.

## Operation
- Per-button datapath, three identical instances:
  - 2-flop synchronizer.
  - Debounce counter (width ceil(log2(DEBOUNCE_CYCLES))+1).
  - Debounced level register `db`.
  - Previous-level register for edge detection.
- Debounce counter behaviour:
  - While the synchronized input equals `db`, the counter is held at 0.
  - While it differs, the counter increments every cycle.
  - Any cycle where the input returns to `db` clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the input still differs, `db` takes the new level and the counter clears.
- Press event: a rising edge of `db` (0 to 1). Falling edges are debounced the same way but generate no event.
- Mode press: `sel` ← `sel`+1, and wraps from NUM_MODES-1 to 0. `reg_idx` is unchanged.
- Reg press: `reg_idx` ← `reg_idx`+1, 5-bit wrap from 31 to 0. `reg_idx` advances regardless of `sel`. `sel` is unchanged.
- Step press: `step_pulse`=1 for exactly one cycle, otherwise 0. A held button never repeats.
- Simultaneous presses in the same cycle: all events apply independently in that cycle.
- A button held through reset release counts as a press once debounced, because `db` resets to 0.
- `rst` asserted mid-operation resets the outputs as below and clears all synchronizers, counters and `db` registers immediately; no pending press survives.

## Timing
- Reset values: `sel`=0, `reg_idx`=0, `step_pulse`=0. All internal registers are 0.
- Latency: a raw input rising cleanly and sampled high at edge E produces its output change at edge E+DEBOUNCE_CYCLES+3:
  - 2 edges of synchronization.
  - DEBOUNCE_CYCLES edges of counting/acceptance.
  - 1 edge of edge-detect/output register.
- Release is also accepted after the same latency. A new press then requires a fresh stable-high window.
- Bounce: any raw pulse, high or low, shorter than DEBOUNCE_CYCLES cycles after synchronization produces no event.
- `sel` and `reg_idx` change only on press events and are stable between them. `step_pulse` never stays high longer than one cycle.
- No combinational path from any input to any output.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, so latency is 7 edges.

- **Reset / reset mid-press:**
  - Stimulus: assert `rst` with all buttons at 0.
  - Response: `sel`=0, `reg_idx`=0, `step_pulse`=0 immediately, without waiting for a clock edge.
  - Stimulus: raise `btn_mode`, then pulse `rst` at edge E+3.
  - Response: `sel` stays 0, and the press is re-debounced from scratch after reset is released.
- **Mode wrap:**
  - Stimulus: 6 clean `btn_mode` presses (high 10 cycles, low 10 cycles).
  - Response: `sel` steps 1,2,3,4,5,0; each change occurs exactly 7 edges after the raw rise.
- **Register wrap:**
  - Stimulus: 33 clean `btn_reg` presses.
  - Response: `reg_idx` goes 1..31, 0, 1; `sel` stays unchanged.
- **Bounce rejection:**
  - Stimulus: on `btn_step`, apply high 3 cycles, low 1, high 2, low 1, then high 10.
  - Response: no pulse during the bounce, then exactly one `step_pulse` 7 edges after the final rise.
- **Hold / simultaneous:**
  - Stimulus: hold `btn_step` high for 100 cycles.
  - Response: exactly one `step_pulse`.
  - Stimulus: raise `btn_mode` and `btn_reg` on the same edge.
  - Response: `sel` and `reg_idx` both increment on the same edge.
